rtc_ctrl_module: RTL and testbench

RTC_CTRL_MODULE -- requirements
Module: rtc_ctrl_module

---
 rtl/rtc_ctrl_module.sv | 159 +++++++++++++++
 tb/tb_rtc_ctrl_module.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_ctrl_module.sv
// DS1302 RTC controller: disables write protect after reset, then services time
// set requests and periodic hour/minute/second reads through a byte engine.
module rtc_ctrl_module #(
  parameter int unsigned POLL_PERIOD = 25000000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       set_req,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  output logic [1:0] func_start_sig,
  output logic [7:0] words_addr,
  output logic [7:0] write_data,
  input  logic [7:0] read_data,
  input  logic       func_done_sig,
  output logic [7:0] time_hour,
  output logic [7:0] time_min,
  output logic [7:0] time_sec,
  output logic       time_valid,
  output logic       busy
);

  localparam int unsigned CW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {
    INIT_WP, IDLE, SET_H, SET_M, SET_S, RD_H, RD_M, RD_S
  } state_t;

  state_t        state, state_next, seq_next;
  logic [1:0]    start_next;
  logic [7:0]    addr_next, data_next;
  logic          cmd_wr;
  logic [7:0]    cmd_addr, cmd_data;
  logic          cmd_done;
  logic          leave_set, leave_poll;
  logic          set_pend, poll_pend;
  logic [7:0]    set_hour_q, set_min_q, set_sec_q;
  logic [7:0]    sh_hour, sh_min, sh_sec;
  logic          upd_pend;
  logic [CW-1:0] poll_cnt;
  logic          poll_wrap;

  assign busy      = (state != IDLE);
  assign poll_wrap = (poll_cnt == POLL_LAST);
  assign cmd_done  = (func_start_sig != 2'b00) && func_done_sig;

  // Command issued by each sequence state and the state that follows it.
  always_comb begin
    cmd_wr   = 1'b0;
    cmd_addr = '0;
    cmd_data = '0;
    seq_next = IDLE;
    case (state)
      INIT_WP: begin cmd_wr = 1'b1; cmd_addr = 8'h8E; end
      SET_H:   begin cmd_wr = 1'b1; cmd_addr = 8'h84; cmd_data = set_hour_q; seq_next = SET_M; end
      SET_M:   begin cmd_wr = 1'b1; cmd_addr = 8'h82; cmd_data = set_min_q;  seq_next = SET_S; end
      SET_S:   begin cmd_wr = 1'b1; cmd_addr = 8'h80; cmd_data = {1'b0, set_sec_q[6:0]}; end
      RD_H:    begin cmd_addr = 8'h85; seq_next = RD_M; end
      RD_M:    begin cmd_addr = 8'h83; seq_next = RD_S; end
      RD_S:    begin cmd_addr = 8'h81; end
      default: ;
    endcase
  end

  // A state issues its command only while start is idle, so every command is
  // preceded by at least one full cycle of 00 after the previous completion.
  always_comb begin
    state_next = state;
    start_next = func_start_sig;
    addr_next  = words_addr;
    data_next  = write_data;
    leave_set  = 1'b0;
    leave_poll = 1'b0;
    if (state == IDLE) begin
      if (set_pend) begin
        state_next = SET_H;
        leave_set  = 1'b1;
      end else if (poll_pend) begin
        state_next = RD_H;
        leave_poll = 1'b1;
      end
    end else if (func_start_sig == 2'b00) begin
      start_next = cmd_wr ? 2'b10 : 2'b01;
      addr_next  = cmd_addr;
      data_next  = cmd_data;
    end else if (func_done_sig) begin
      start_next = 2'b00;
      state_next = seq_next;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state          <= INIT_WP;
      func_start_sig <= '0;
      words_addr     <= '0;
      write_data     <= '0;
    end else begin
      state          <= state_next;
      func_start_sig <= start_next;
      words_addr     <= addr_next;
      write_data     <= data_next;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      poll_cnt   <= '0;
      poll_pend  <= 1'b0;
      set_pend   <= 1'b0;
      set_hour_q <= '0;
      set_min_q  <= '0;
      set_sec_q  <= '0;
      sh_hour    <= '0;
      sh_min     <= '0;
      sh_sec     <= '0;
      upd_pend   <= 1'b0;
      time_hour  <= '0;
      time_min   <= '0;
      time_sec   <= '0;
      time_valid <= 1'b0;
    end else begin
      poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;

      if (poll_wrap)       poll_pend <= 1'b1;
      else if (leave_poll) poll_pend <= 1'b0;

      // A coincident request keeps set_pend high so the new values are not lost.
      if (set_req) begin
        set_hour_q <= set_hour;
        set_min_q  <= set_min;
        set_sec_q  <= set_sec;
        set_pend   <= 1'b1;
      end else if (leave_set) begin
        set_pend <= 1'b0;
      end

      upd_pend   <= 1'b0;
      time_valid <= 1'b0;
      if (cmd_done) begin
        case (state)
          RD_H:    sh_hour <= read_data;
          RD_M:    sh_min  <= read_data;
          RD_S:    begin sh_sec <= read_data; upd_pend <= 1'b1; end
          default: ;
        endcase
      end
      if (upd_pend) begin
        time_hour  <= sh_hour;
        time_min   <= sh_min;
        time_sec   <= sh_sec & 8'h7F;
        time_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rtc_ctrl_module.sv
// Directed bench for rtc_ctrl_module with a 40-cycle byte-engine model.
module tb_rtc_ctrl_module;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       set_req;
  logic [7:0] set_hour, set_min, set_sec;
  logic [1:0] func_start_sig;
  logic [7:0] words_addr, write_data;
  logic [7:0] read_data;
  logic       func_done_sig;
  logic [7:0] time_hour, time_min, time_sec;
  logic       time_valid;
  logic       busy;

  rtc_ctrl_module #(.POLL_PERIOD(200)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .set_req(set_req), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .func_start_sig(func_start_sig), .words_addr(words_addr), .write_data(write_data),
    .read_data(read_data), .func_done_sig(func_done_sig),
    .time_hour(time_hour), .time_min(time_min), .time_sec(time_sec),
    .time_valid(time_valid), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Command log filled by the engine model (1-based).
  logic [1:0] log_op   [0:63];
  logic [7:0] log_addr [0:63];
  logic [7:0] log_data [0:63];
  int         n_cmd = 0;
  int         n_done = 0;

  logic [7:0] rd_h = 8'h12, rd_m = 8'h34, rd_s = 8'hB6;

  // Engine model: sees start at a negedge, pulses done 40 negedges later.
  initial begin
    logic       act;
    int         cnt;
    logic [1:0] op;
    logic [7:0] a, d;
    act = 1'b0; cnt = 0; op = '0; a = '0; d = '0;
    func_done_sig = 1'b0;
    read_data     = 8'h00;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        func_done_sig = 1'b0;
        act = 1'b0;
      end else if (func_done_sig) begin
        func_done_sig = 1'b0;
        n_done++;
        check("start_drop", {30'd0, func_start_sig}, 32'd0);
      end else if (act) begin
        cnt++;
        if (cnt == 40) begin
          check("cmd_hold", {14'd0, func_start_sig, words_addr, write_data}, {14'd0, op, a, d});
          case (a)
            8'h85:   read_data = rd_h;
            8'h83:   read_data = rd_m;
            8'h81:   read_data = rd_s;
            default: read_data = 8'h00;
          endcase
          func_done_sig = 1'b1;
          act = 1'b0;
        end
      end else if (func_start_sig != 2'b00) begin
        op = func_start_sig; a = words_addr; d = write_data;
        n_cmd++;
        log_op[n_cmd] = op; log_addr[n_cmd] = a; log_data[n_cmd] = d;
        act = 1'b1;
        cnt = 0;
      end
    end
  end

  int         valid_cnt = 0;
  int         valid_long = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] vh, vm, vs;

  initial begin
    forever begin
      @(negedge CLK);
      if (time_valid) begin
        valid_cnt++;
        vh = time_hour; vm = time_min; vs = time_sec;
        if (valid_prev) valid_long++;
      end
      valid_prev = time_valid;
    end
  end

  task automatic wait_cmds(input int n);
    int b;
    b = 0;
    while (n_cmd < n && b < 600) begin
      @(negedge CLK);
      b++;
    end
    if (n_cmd < n) check($sformatf("wait_cmd%0d", n), n_cmd, n);
  endtask

  task automatic chk_cmd(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    check($sformatf("cmd%0d_op", i), {30'd0, log_op[i]}, {30'd0, op});
    check($sformatf("cmd%0d_addr", i), {24'd0, log_addr[i]}, {24'd0, a});
    if (op == 2'b10) check($sformatf("cmd%0d_data", i), {24'd0, log_data[i]}, {24'd0, d});
  endtask

  task automatic pulse_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    @(negedge CLK);
    set_hour = h; set_min = m; set_sec = s; set_req = 1'b1;
    @(negedge CLK);
    set_req = 1'b0;
  endtask

  initial begin
    int b;
    RSTn = 1'b0; set_req = 1'b0; set_hour = '0; set_min = '0; set_sec = '0;
    repeat (3) @(negedge CLK);
    check("rst_start", {30'd0, func_start_sig}, 32'd0);
    check("rst_addr_data", {16'd0, words_addr, write_data}, 32'd0);
    check("rst_time", {8'd0, time_hour, time_min, time_sec}, 32'd0);
    check("rst_valid", {31'd0, time_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    RSTn = 1'b1;

    // Write-protect off after reset, then idle.
    wait_cmds(1);
    chk_cmd(1, 2'b10, 8'h8E, 8'h00);
    b = 0;
    while (n_done < 1 && b < 100) begin @(negedge CLK); b++; end
    check("init_done", n_done, 1);
    @(negedge CLK);
    check("init_idle_busy", {31'd0, busy}, 32'd0);
    check("init_idle_start", {30'd0, func_start_sig}, 32'd0);

    // First poll wrap: read hour, minute, second.
    b = 0;
    while (valid_cnt < 1 && b < 600) begin @(negedge CLK); b++; end
    check("poll1_valid", valid_cnt, 1);
    chk_cmd(2, 2'b01, 8'h85, 8'h00);
    chk_cmd(3, 2'b01, 8'h83, 8'h00);
    chk_cmd(4, 2'b01, 8'h81, 8'h00);
    check("poll1_vals", {8'd0, vh, vm, vs}, 32'h00123436);
    repeat (3) @(negedge CLK);
    check("poll1_time", {8'd0, time_hour, time_min, time_sec}, 32'h00123436);
    check("poll1_one_pulse", valid_cnt, 1);

    // Set request during RD_M of the second poll: reads finish first.
    wait_cmds(6);
    pulse_set(8'h23, 8'h59, 8'hD8);
    wait_cmds(10);
    chk_cmd(7, 2'b01, 8'h81, 8'h00);
    chk_cmd(8, 2'b10, 8'h84, 8'h23);
    chk_cmd(9, 2'b10, 8'h82, 8'h59);
    chk_cmd(10, 2'b10, 8'h80, 8'h58);
    check("poll2_valid", valid_cnt, 2);

    // Poll wrap during the set sequence -> reads follow; reset mid RD_M.
    wait_cmds(12);
    chk_cmd(11, 2'b01, 8'h85, 8'h00);
    chk_cmd(12, 2'b01, 8'h83, 8'h00);
    repeat (5) @(negedge CLK);
    #2 RSTn = 1'b0;
    #1;
    check("rst_mid_start", {30'd0, func_start_sig}, 32'd0);
    check("rst_mid_time", {8'd0, time_hour, time_min, time_sec}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd1);
    n_cmd = 0; n_done = 0; valid_cnt = 0;
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;

    // Set request during INIT_WP runs right after init.
    wait_cmds(1);
    chk_cmd(1, 2'b10, 8'h8E, 8'h00);
    pulse_set(8'h11, 8'h22, 8'hB3);
    wait_cmds(4);
    chk_cmd(2, 2'b10, 8'h84, 8'h11);
    chk_cmd(3, 2'b10, 8'h82, 8'h22);
    chk_cmd(4, 2'b10, 8'h80, 8'h33);

    // Two set requests during a read sequence: last one wins, one set sequence.
    wait_cmds(5);
    pulse_set(8'h01, 8'h10, 8'h20);
    repeat (3) @(negedge CLK);
    pulse_set(8'h02, 8'h45, 8'h30);
    wait_cmds(8);
    chk_cmd(5, 2'b01, 8'h85, 8'h00);
    chk_cmd(6, 2'b01, 8'h83, 8'h00);
    chk_cmd(7, 2'b01, 8'h81, 8'h00);
    chk_cmd(8, 2'b10, 8'h84, 8'h02);
    check("epoch2_valid", valid_cnt, 1);
    wait_cmds(11);
    chk_cmd(9, 2'b10, 8'h82, 8'h45);
    chk_cmd(10, 2'b10, 8'h80, 8'h30);
    chk_cmd(11, 2'b01, 8'h85, 8'h00);
    check("valid_width", valid_long, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "global timeout");
  end

endmodule
